// File: rtl/demux_rr_dispatcher.sv
// Purpose : steers each accepted upstream word into a one-entry holding register per output channel, target picked round-robin (mode=0) or by fix_sel (mode=1).
// Latency : one cycle from the accepting edge to out_valid on the target channel.
// Backpressure: in_ready follows the target channel only (free, or draining this cycle); other channels never stall the input.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   upstream valid/ready word stream
//   mode, fix_sel    target selection: 0 = round-robin pointer, 1 = fix_sel
//   sel              channel the next accepted word goes to (for combinational demux stages)
//   out_valid/out_ready/out_data per-channel handshakes; channel i at out_data[i*WIDTH +: WIDTH]
//   acc_cnt          wrapping count of accepted words
//   err_sel          sticky: a word was offered while fix_sel was out of range
//
// Parameter constraints: 2 <= NCH <= 16, 2**SELW >= NCH.
module demux_rr_dispatcher #(
  parameter int WIDTH = 8,
  parameter int NCH   = 2,
  parameter int SELW  = 1,
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   mode,
  input  logic [SELW-1:0]        fix_sel,
  output logic [SELW-1:0]        sel,
  output logic [NCH-1:0]         out_valid,
  input  logic [NCH-1:0]         out_ready,
  output logic [NCH*WIDTH-1:0]   out_data,
  output logic [CNTW-1:0]        acc_cnt,
  output logic                   err_sel
);

  // One extra bit so NCH itself is representable when 2**SELW == NCH.
  localparam logic [SELW:0]   NCH_X = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

  logic [SELW-1:0]             ptr;
  logic [SELW-1:0]             tgt;
  logic                        tgt_ok;
  logic                        tgt_full;
  logic                        tgt_drain;
  logic                        acc;
  logic [NCH-1:0]              full;
  logic [NCH-1:0]              load;
  logic [NCH-1:0]              drain;
  logic [NCH-1:0][WIDTH-1:0]   data_q;

  // ------------------------------------------------------------------
  // Target selection and ready
  // ------------------------------------------------------------------
  assign tgt    = mode ? fix_sel : ptr;
  assign sel    = tgt;
  assign tgt_ok = {1'b0, tgt} < NCH_X;

  // Look up the target channel's state by compare rather than by index so
  // an out-of-range fix_sel never produces an out-of-bounds select.
  always_comb begin
    tgt_full  = 1'b0;
    tgt_drain = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (tgt == SELW'(i)) begin
        tgt_full  = full[i];
        tgt_drain = out_ready[i];
      end
    end
  end

  // Downstream ready passes straight through so a streaming channel takes a
  // new word on the same edge its old one leaves: no bubble.
  assign in_ready = tgt_ok && (!tgt_full || tgt_drain);
  assign acc      = in_valid && in_ready;
  assign drain    = full & out_ready;

  // ------------------------------------------------------------------
  // Per-channel holding registers
  // ------------------------------------------------------------------
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign load[g] = acc && (tgt == SELW'(g));

    // Load wins over drain: a same-cycle drain+load leaves the slot full
    // with the new word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        full[g]   <= 1'b0;
        data_q[g] <= '0;
      end else if (load[g]) begin
        full[g]   <= 1'b1;
        data_q[g] <= in_data;
      end else if (drain[g]) begin
        full[g]   <= 1'b0;
      end
    end
  end

  assign out_valid = full;
  assign out_data  = data_q;

  // ------------------------------------------------------------------
  // Round-robin pointer: advances only on accepts made in round-robin
  // mode, never skips a busy channel, and is frozen while in fixed mode.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (acc && !mode) begin
      ptr <= (ptr == LAST) ? '0 : ptr + SELW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Accept counter and sticky select error
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (acc) begin
      acc_cnt <= acc_cnt + CNTW'(1);
    end
  end

  // Only fixed mode can be out of range; the pointer always wraps at NCH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else if (in_valid && mode && !tgt_ok) begin
      err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: scoreboard of expected words per channel,
// pushed when the bench sees an accept and popped on each downstream handshake.
// A second instance with NCH=3 covers the out-of-range fixed select.
module tb_demux_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // NCH = 2 instance
  logic        in_valid, in_ready, mode, err_sel;
  logic [7:0]  in_data;
  logic [0:0]  fix_sel, sel;
  logic [1:0]  out_valid, out_ready;
  logic [15:0] out_data, acc_cnt;

  // NCH = 3 instance
  logic        in_valid3, in_ready3, mode3, err_sel3;
  logic [7:0]  in_data3;
  logic [1:0]  fix_sel3, sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;
  logic [15:0] acc_cnt3;

  demux_rr_dispatcher #(.WIDTH(8), .NCH(2), .SELW(1), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mode(mode), .fix_sel(fix_sel), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .acc_cnt(acc_cnt), .err_sel(err_sel)
  );

  demux_rr_dispatcher #(.WIDTH(8), .NCH(3), .SELW(2), .CNTW(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .mode(mode3), .fix_sel(fix_sel3), .sel(sel3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .acc_cnt(acc_cnt3), .err_sel(err_sel3)
  );

  int         n_run  = 0;
  int         n_fail = 0;
  int         rr_ptr = 0;   // model of the round-robin pointer
  int         exp_acc = 0;  // model of acc_cnt
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Negedge sample: pop/compare every channel handshaking on the coming edge.
  task automatic sb_step();
    logic [7:0] got, want;
    @(negedge clk);
    for (int ch = 0; ch < 2; ch++) begin
      if (out_valid[ch] && out_ready[ch]) begin
        got = out_data[ch*8 +: 8];
        n_run++;
        if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected ch%0d: got %h, expected no word", ch, got);
        end else begin
          want = (ch == 0) ? q0.pop_front() : q1.pop_front();
          if (got !== want) begin
            n_fail++;
            $display("FAIL sb_data ch%0d: got %h, expected %h", ch, got, want);
          end
        end
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      sb_step();
      edge_step();
    end
  endtask

  // Offer one word until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input logic [7:0] d, output int waits);
    int  t;
    bit  done;
    t     = mode ? int'(fix_sel) : rr_ptr;
    done  = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done) begin
      sb_step();
      if (waits == 0) begin
        n_run++;
        if (sel !== 1'(t)) begin
          n_fail++;
          $display("FAIL sel_for_%h: got %0d, expected %0d", d, sel, t);
        end
      end
      if (in_ready) begin
        if (t == 0) q0.push_back(d); else q1.push_back(d);
        exp_acc++;
        if (!mode) rr_ptr = (rr_ptr + 1) % 2;
        done = 1'b1;
      end else begin
        waits++;
      end
      edge_step();
      if (!done && waits > 50) begin
        n_run++;
        n_fail++;
        $display("FAIL send_timeout %h: waited %0d cycles, expected accept", d, waits);
        done = 1'b1;
      end
    end
  endtask

  task automatic check_acc(input string tag);
    n_run++;
    if (acc_cnt !== 16'(exp_acc)) begin
      n_fail++;
      $display("FAIL acc_cnt_%s: got %0d, expected %0d", tag, acc_cnt, exp_acc);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_run++;
    if (out_valid !== 2'b00 || acc_cnt !== 16'd0 || err_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b cnt=%0d err=%b, expected 00/0/0", out_valid, acc_cnt, err_sel);
    end
    n_run++;
    if (in_ready !== 1'b1 || sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got rdy=%b sel=%0d, expected 1/0", in_ready, sel);
    end
    edge_step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int w;
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    mode = 1'b0; out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      send(words[i], w);
      n_run++;
      if (w !== 0) begin
        n_fail++;
        $display("FAIL b2b_stall word%0d: got %0d wait cycles, expected 0", i, w);
      end
    end
    idle(2);
    check_acc("b2b");
    n_run++;
    if (out_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_drained: got ov=%b, expected 00", out_valid);
    end
  endtask

  task automatic test_rr_stall();
    int w;
    out_ready = 2'b01;
    send(8'h11, w);
    send(8'h22, w);
    send(8'h33, w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL rr_other_channel: got %0d waits for 33, expected 0", w);
    end
    in_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      sb_step();
      n_run++;
      if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || out_data[15:8] !== 8'h22) begin
        n_fail++;
        $display("FAIL rr_stall cyc%0d: got rdy=%b ov1=%b d1=%h, expected 0/1/22",
                 i, in_ready, out_valid[1], out_data[15:8]);
      end
      edge_step();
    end
    out_ready = 2'b11;
    send(8'h44, w);
    n_run++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL rr_release: got %0d waits, expected same-cycle accept", w);
    end
    idle(2);
    check_acc("rr");
  endtask

  task automatic test_fixed();
    int idx, cyc;
    logic [2:0] pat;
    pat = 3'b101;
    idx = 0; cyc = 0;
    mode = 1'b1; fix_sel = 1'b1; out_ready = 2'b01;
    while (idx < 4 && cyc < 40) begin
      out_ready[1] = pat[cyc % 3];
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + idx);
      sb_step();
      n_run++;
      if (sel !== 1'b1) begin
        n_fail++;
        $display("FAIL fixed_sel cyc%0d: got %0d, expected 1", cyc, sel);
      end
      if (in_ready) begin
        q1.push_back(in_data);
        exp_acc++;
        idx++;
      end
      edge_step();
      cyc++;
    end
    n_run++;
    if (idx !== 4) begin
      n_fail++;
      $display("FAIL fixed_count: got %0d accepted, expected 4", idx);
    end
    in_valid = 1'b0; out_ready = 2'b11; mode = 1'b0;
    idle(3);
    check_acc("fixed");
    n_run++;
    if (sel !== 1'(rr_ptr)) begin
      n_fail++;
      $display("FAIL fixed_ptr_held: got %0d, expected %0d", sel, rr_ptr);
    end
  endtask

  task automatic test_drain_load();
    int w;
    mode = 1'b0; out_ready = 2'b00;
    send(8'h66, w);
    in_valid = 1'b0;
    mode = 1'b1; fix_sel = 1'b0; out_ready = 2'b01;
    send(8'h77, w);
    n_run++;
    if (w !== 0 || out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h77) begin
      n_fail++;
      $display("FAIL drain_load: got waits=%0d ov0=%b d0=%h, expected 0/1/77",
               w, out_valid[0], out_data[7:0]);
    end
    mode = 1'b0; out_ready = 2'b11;
    idle(2);
    check_acc("dl");
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 2'b00;
    send(8'h81, w);
    send(8'h82, w);
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_loaded: got ov=%b, expected 11", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_run++;
    if (out_valid !== 2'b00 || acc_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_async_reset: got ov=%b cnt=%0d, expected 00/0", out_valid, acc_cnt);
    end
    q0.delete(); q1.delete();
    rr_ptr = 0; exp_acc = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    out_ready = 2'b11;
    send(8'h90, w);
    idle(2);
    check_acc("post_rst");
  endtask

  task automatic test_err_sel();
    mode3 = 1'b1; fix_sel3 = 2'd3; in_data3 = 8'hE5; in_valid3 = 1'b1;
    @(negedge clk);
    n_run++;
    if (in_ready3 !== 1'b0 || err_sel3 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_block: got rdy=%b err=%b, expected 0/0", in_ready3, err_sel3);
    end
    edge_step();
    n_run++;
    if (err_sel3 !== 1'b1 || out_valid3 !== 3'b000) begin
      n_fail++;
      $display("FAIL err_set: got err=%b ov=%b, expected 1/000", err_sel3, out_valid3);
    end
    fix_sel3 = 2'd2;
    @(negedge clk);
    n_run++;
    if (in_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL err_resume_ready: got %b, expected 1", in_ready3);
    end
    edge_step();
    in_valid3 = 1'b0;
    n_run++;
    if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'hE5 || err_sel3 !== 1'b1 || acc_cnt3 !== 16'd1) begin
      n_fail++;
      $display("FAIL err_resume: got ov=%b d2=%h err=%b cnt=%0d, expected 100/e5/1/1",
               out_valid3, out_data3[23:16], err_sel3, acc_cnt3);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 8'h00; mode = 1'b0; fix_sel = 1'b0; out_ready = 2'b11;
    in_valid3 = 1'b0; in_data3 = 8'h00; mode3 = 1'b0; fix_sel3 = 2'd0; out_ready3 = 3'b111;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_rr_stall();
    test_fixed();
    test_drain_load();
    test_reset_mid();
    test_err_sel();
    n_run++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d/%0d words undelivered, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
